data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data SRAM port (data_sram_wen/addr/wdata/rdata).
- Holds a word-addressed data RAM plus a small confreg window: LEDs, seven-segment value, switches and a free-running timer.
- Drives an eight-digit multiplexed seven-segment display through a scan counter.
- Sits beside mycpu_top at SoC level; it is the responder to the core's data initiator.

Parameters:
- ADDR_W, 10, RAM index width; RAM holds 2^ADDR_W 32-bit words.
- SCAN_DIV, 16'd50000, clk cycles per display digit; minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_sram_wen  input  1  write strobe, one full word per cycle.
- data_sram_addr  input  32  byte address; bits [1:0] ignored.
- data_sram_wdata  input  32  write data.
- data_sram_rdata  output  32  registered read data.
- switch  input  8  board switches, asynchronous to clk.
- led  output  16  LED drive, active-low.
- num_csn  output  8  digit select, active-low one-hot.
- num_a_g  output  7  segments a..g, bit 6 = a, active-high.

Behaviour:
- Decode
  - conf_hit = (addr[31:16] == 16'hBFAF).
  - Otherwise RAM access at index addr[ADDR_W+1:2]. Upper bits alias.
- Confreg offsets (addr[15:0]):
  - 16'hF000 LED: RW, bits [15:0]; reads zero-extended.
  - 16'hF010 NUM: RW, 32 bits; eight hex nibbles, digit i = NUM[4i+3:4i].
  - 16'hF020 SWITCH: RO, zero-extended; writes ignored.
  - 16'hE000 TIMER: RW, 32 bits.
  - Any other offset: reads 0, writes ignored.
- Read latency
  - Every cycle, data_sram_rdata is loaded with the content at the cycle's address, sampled before that cycle's write. This is read-first.
  - The value is visible in the following cycle. A read is performed every cycle regardless of data_sram_wen.
  - Write then read of the same address on consecutive cycles returns the new value.
- Writes occur at the rising edge when data_sram_wen = 1.
- TIMER
  - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A write in the same cycle wins: TIMER <= wdata. The increment resumes the next cycle.
  - Read returns the pre-edge value.
- SWITCH
  - Two-flop synchronizer. The register value lags pin changes by 2 cycles.
  - Read adds 1 more cycle, for 3 cycles total.
- Scan machine
  - div counter runs 0..SCAN_DIV-1.
  - On div = SCAN_DIV-1: div <= 0 and idx <= idx+1 (3-bit, wraps 7 -> 0).
  - num_csn = ~(8'b1 << idx).
  - num_a_g = seg7 pattern of the NUM nibble at idx.
  - Both outputs are registered: they change one cycle after idx changes.
  - NUM updates are reflected at the next output register update with no restart of the scan.
- Reset (asynchronous, immediate, also mid-operation)
  - data_sram_rdata = 0, led = 16'hFFFF, NUM = 0, TIMER = 0.
  - Synchronizer flops = 0, div = 0, idx = 0.
  - num_csn = 8'hFE, num_a_g = 7'b1111110.
  - RAM contents are not reset.
- seg7 encoding, hex 0..F: 7E, 30, 6D, 79, 33, 5B, 5F, 70, 7F, 7B, 77, 1F, 4E, 3D, 4F, 47.

Decomposition:
- Shared package: CONF_BASE_HI = 16'hBFAF, offsets LED/NUM/SWITCH/TIMER, LED_RESET = 16'hFFFF.
- One sub-module, seg7_decode: 4-bit hex in, 7-bit a..g out, purely combinational. It is instantiated once on the selected nibble.

Test Plan:
- Reset mid-run, then release → rdata = 0, led = FFFF, num_csn = FE, num_a_g = 7E, TIMER read = small count since release.
- Write 32'hDEAD_BEEF to 0x0000_0010, read the next cycle → rdata = DEADBEEF. Read 0x0000_1010 with ADDR_W = 10 → same word (alias).
- Write 32'h0000_A5A5 to 0xBFAF_F000 → led = A5A5 after the edge. Read back → 0000A5A5. Read 0xBFAF_F004 → 0.
- Write TIMER = FFFF_FFFE, then idle → reads sequence FFFFFFFF, 00000000, 00000001. A write coinciding with the increment loads wdata exactly.
- Set switch = 8'h3C asynchronously → SWITCH read equals 0000003C no earlier than 3 cycles after the change. A write to SWITCH is ignored.
- SCAN_DIV = 4, NUM = 32'h7654_3210 → num_csn steps FE, FD, FB, ..., 7F, FE every 4 cycles, with num_a_g 7E, 30, 6D, 79, 33, 5B, 5F, 70 in step.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared constants and confreg decode for the data SRAM responder.
package data_sram_responder_pkg;

  localparam logic [15:0] CONF_BASE_HI = 16'hBFAF;
  localparam logic [15:0] OFF_LED      = 16'hF000;
  localparam logic [15:0] OFF_NUM      = 16'hF010;
  localparam logic [15:0] OFF_SWITCH   = 16'hF020;
  localparam logic [15:0] OFF_TIMER    = 16'hE000;
  localparam logic [15:0] LED_RESET    = 16'hFFFF;
  localparam logic [7:0]  CSN_RESET    = 8'hFE;
  localparam logic [6:0]  SEG_RESET    = 7'b1111110;

  typedef enum logic [2:0] {
    CONF_NONE,
    CONF_LED,
    CONF_NUM,
    CONF_SWITCH,
    CONF_TIMER
  } conf_sel_e;

  function automatic conf_sel_e conf_decode(input logic [15:0] off);
    conf_sel_e sel;
    sel = CONF_NONE;
    case (off)
      OFF_LED:    sel = CONF_LED;
      OFF_NUM:    sel = CONF_NUM;
      OFF_SWITCH: sel = CONF_SWITCH;
      OFF_TIMER:  sel = CONF_TIMER;
      default:    sel = CONF_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/data_sram_responder_seg7_decode.sv
// Hex nibble to seven-segment pattern, bit 6 = segment a, active-high.
module seg7_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM, confreg window (LED/NUM/SWITCH/TIMER)
// and an eight-digit multiplexed seven-segment scanner.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g
);

  logic              conf_hit;
  conf_sel_e         sel;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       conf_rdata;
  logic [31:0]       rd_next;

  logic [31:0]       num_q;
  logic [31:0]       timer_q;
  logic [1:0][7:0]   sw_sync;
  logic [15:0]       div_q;
  logic [2:0]        idx_q;
  logic [3:0]        nibble;
  logic [6:0]        seg_next;

  logic [31:0]       mem [2**ADDR_W];

  assign conf_hit = (data_sram_addr[31:16] == CONF_BASE_HI);
  assign sel      = conf_hit ? conf_decode(data_sram_addr[15:0]) : CONF_NONE;
  assign ram_idx  = data_sram_addr[ADDR_W+1:2];

  always_comb begin
    conf_rdata = 32'h0;
    case (sel)
      CONF_LED:    conf_rdata = {16'h0, led};
      CONF_NUM:    conf_rdata = num_q;
      CONF_SWITCH: conf_rdata = {24'h0, sw_sync[1]};
      CONF_TIMER:  conf_rdata = timer_q;
      default:     conf_rdata = 32'h0;
    endcase
  end

  // Read-first: the mux samples RAM/conf state before this edge's write lands.
  assign rd_next = conf_hit ? conf_rdata : mem[ram_idx];

  always_ff @(posedge clk)
    if (data_sram_wen && !conf_hit) mem[ram_idx] <= data_sram_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= 32'h0;
      led             <= LED_RESET;
      num_q           <= 32'h0;
      timer_q         <= 32'h0;
      sw_sync         <= '0;
    end else begin
      data_sram_rdata <= rd_next;
      sw_sync         <= {sw_sync[0], switch};
      if (data_sram_wen && sel == CONF_LED) led   <= data_sram_wdata[15:0];
      if (data_sram_wen && sel == CONF_NUM) num_q <= data_sram_wdata;
      if (data_sram_wen && sel == CONF_TIMER) timer_q <= data_sram_wdata;
      else                                    timer_q <= timer_q + 32'd1;
    end
  end

  assign nibble = num_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_seg7 (
    .hex (nibble),
    .seg (seg_next)
  );

  // Digit outputs are registered from the current idx, so they trail idx by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= 16'h0;
      idx_q   <= 3'd0;
      num_csn <= CSN_RESET;
      num_a_g <= SEG_RESET;
    end else begin
      if (div_q == SCAN_DIV - 16'd1) begin
        div_q <= 16'h0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + 16'd1;
      end
      num_csn <= ~(8'd1 << idx_q);
      num_a_g <= seg_next;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a per-cycle reference model.
module tb_data_sram_responder;

  localparam logic [31:0] A_IDLE   = 32'hBFAF_0000;
  localparam logic [31:0] A_LED    = 32'hBFAF_F000;
  localparam logic [31:0] A_NUM    = 32'hBFAF_F010;
  localparam logic [31:0] A_SWITCH = 32'hBFAF_F020;
  localparam logic [31:0] A_TIMER  = 32'hBFAF_E000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wen;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [7:0]  csn;
  logic [6:0]  ag;

  int n_cmp = 0;
  int n_err = 0;

  data_sram_responder #(.ADDR_W(10), .SCAN_DIV(16'd4)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .num_csn         (csn),
    .num_a_g         (ag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    wen = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  // Reference model: state updated from the rules at each rising edge.
  logic [6:0]  seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [31:0] m_mem [1024];
  bit          m_val [1024];
  logic [31:0] m_num, m_timer, e_rdata, m_rd;
  logic [15:0] m_led;
  logic [7:0]  m_s1, m_s2, e_csn;
  logic [6:0]  e_seg;
  bit          e_rvalid, m_rv;
  int          m_n, m_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rdata = 32'h0; e_rvalid = 1'b1;
      m_led = 16'hFFFF; m_num = 32'h0; m_timer = 32'h0;
      m_s1 = 8'h0; m_s2 = 8'h0; m_n = 0;
      e_csn = 8'hFE; e_seg = 7'h7E;
    end else begin
      m_d   = (m_n / 4) % 8;
      e_csn = ~(8'd1 << m_d);
      e_seg = seg_tab[m_num[m_d*4 +: 4]];
      m_rv = 1'b1; m_rd = 32'h0;
      if (addr[31:16] == 16'hBFAF) begin
        case (addr[15:0])
          16'hF000: m_rd = {16'h0, m_led};
          16'hF010: m_rd = m_num;
          16'hF020: m_rd = {24'h0, m_s2};
          16'hE000: m_rd = m_timer;
          default:  m_rd = 32'h0;
        endcase
      end else begin
        m_rv = m_val[addr[11:2]];
        m_rd = m_mem[addr[11:2]];
      end
      e_rdata = m_rd; e_rvalid = m_rv;
      m_timer = m_timer + 32'd1;
      if (wen) begin
        if (addr[31:16] == 16'hBFAF) begin
          case (addr[15:0])
            16'hF000: m_led = wdata[15:0];
            16'hF010: m_num = wdata;
            16'hE000: m_timer = wdata;
            default: ;
          endcase
        end else begin
          m_mem[addr[11:2]] = wdata;
          m_val[addr[11:2]] = 1'b1;
        end
      end
      m_s2 = m_s1; m_s1 = sw;
      m_n++;
    end
  end

  bit go = 1'b0;
  always @(negedge clk) begin
    if (go) begin
      if (e_rvalid) chk("model rdata", rdata, e_rdata);
      chk("model led", {16'h0, led}, {16'h0, m_led});
      chk("model num_csn", {24'h0, csn}, {24'h0, e_csn});
      chk("model num_a_g", {25'h0, ag}, {25'h0, e_seg});
    end
  end

  logic [7:0] csn_lit [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_lit [8] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev;
    bit found;
    wen = 1'b0; addr = A_IDLE; wdata = 32'h0; sw = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    go = 1'b1;
    drive(1'b1, A_LED, 32'h0000_1234);
    drive(1'b1, A_NUM, 32'h1111_1111);
    repeat (5) drive(1'b0, A_IDLE, 32'h0);

    // Asynchronous reset in mid-cycle must take effect immediately.
    #2 reset = 1'b1;
    #1;
    chk("async rst rdata", rdata, 32'h0);
    chk("async rst led", {16'h0, led}, 32'h0000_FFFF);
    chk("async rst csn", {24'h0, csn}, 32'hFE);
    chk("async rst a_g", {25'h0, ag}, 32'h7E);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("release led", {16'h0, led}, 32'h0000_FFFF);
    drive(1'b0, A_TIMER, 32'h0);
    chk("timer first read", rdata, 32'h0);
    drive(1'b0, A_TIMER, 32'h0);
    chk("timer second read", rdata, 32'h1);

    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_0010, 32'h0);
    chk("ram readback", rdata, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_1010, 32'h0);
    chk("ram alias", rdata, 32'hDEAD_BEEF);
    drive(1'b1, 32'h0000_0010, 32'hCAFE_F00D);
    chk("ram read-first", rdata, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_0010, 32'h0);
    chk("ram overwrite", rdata, 32'hCAFE_F00D);

    drive(1'b1, A_LED, 32'h0000_A5A5);
    chk("led write", {16'h0, led}, 32'h0000_A5A5);
    drive(1'b0, A_LED, 32'h0);
    chk("led read", rdata, 32'h0000_A5A5);
    drive(1'b0, 32'hBFAF_F004, 32'h0);
    chk("unmapped read", rdata, 32'h0);

    drive(1'b1, A_TIMER, 32'hFFFF_FFFE);
    drive(1'b0, A_IDLE, 32'h0);
    drive(1'b0, A_TIMER, 32'h0);
    chk("timer pre-wrap", rdata, 32'hFFFF_FFFF);
    drive(1'b0, A_TIMER, 32'h0);
    chk("timer wrap", rdata, 32'h0);
    drive(1'b0, A_TIMER, 32'h0);
    chk("timer post-wrap", rdata, 32'h1);
    drive(1'b1, A_TIMER, 32'h1234_5678);
    drive(1'b0, A_TIMER, 32'h0);
    chk("timer write wins", rdata, 32'h1234_5678);

    // Switch changes between edges; read path sees it on the third edge.
    wen = 1'b0; addr = A_SWITCH;
    #2 sw = 8'h3C;
    @(negedge clk);
    chk("switch lag 1", rdata, 32'h0);
    @(negedge clk);
    chk("switch lag 2", rdata, 32'h0);
    @(negedge clk);
    chk("switch lag 3", rdata, 32'h0000_003C);
    drive(1'b1, A_SWITCH, 32'h0000_00FF);
    drive(1'b0, A_SWITCH, 32'h0);
    chk("switch ro", rdata, 32'h0000_003C);

    drive(1'b1, A_NUM, 32'h7654_3210);
    prev = csn;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      drive(1'b0, A_IDLE, 32'h0);
      if (prev != 8'hFE && csn == 8'hFE) found = 1'b1;
      else prev = csn;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL scan sync: no return to digit 0 within 64 cycles");
    end else begin
      for (int d = 0; d < 9; d++) begin
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("scan csn d%0d c%0d", d, c), {24'h0, csn}, {24'h0, csn_lit[d % 8]});
          chk($sformatf("scan a_g d%0d c%0d", d, c), {25'h0, ag}, {25'h0, seg_lit[d % 8]});
          drive(1'b0, A_IDLE, 32'h0);
        end
      end
    end
    drive(1'b1, A_NUM, 32'hFFFF_FFFF);
    drive(1'b0, A_IDLE, 32'h0);
    chk("num live update", {25'h0, ag}, 32'h47);
    repeat (3) drive(1'b0, A_IDLE, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
